// File: rtl/eth_stats_pkg.sv
// Purpose : shared constants and types for the MAC statistics counter block.
//   - event index constants for the 1G MAC status strobes
//   - default event count
//   - response FSM state type
//   - helper for the read-index width
package eth_stats_pkg;

  localparam int unsigned ETH_STATS_NUM_EVENTS = 9;

  localparam int unsigned EV_TX_UNDERFLOW     = 0;
  localparam int unsigned EV_TX_FIFO_OVERFLOW = 1;
  localparam int unsigned EV_TX_FIFO_BAD      = 2;
  localparam int unsigned EV_TX_FIFO_GOOD     = 3;
  localparam int unsigned EV_RX_BAD_FRAME     = 4;
  localparam int unsigned EV_RX_BAD_FCS       = 5;
  localparam int unsigned EV_RX_FIFO_OVERFLOW = 6;
  localparam int unsigned EV_RX_FIFO_BAD      = 7;
  localparam int unsigned EV_RX_FIFO_GOOD     = 8;

  typedef enum logic {
    E_IDLE = 1'b0,
    E_RESP = 1'b1
  } resp_state_e;

  // Index width is at least one bit, even for a single counter.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/eth_stats_sat_counter.sv
// Purpose : one saturating event counter.
// Ports   :
//   i_clk  clock
//   i_rst  asynchronous active-high reset
//   i_inc  count one event this cycle
//   i_clr  clear this cycle; the next value is i_inc so a coincident event survives
//   o_cnt  current count (registered)
module eth_stats_sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  // Clear wins over increment; increment stops at all-ones.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= WIDTH'(i_inc);
    end else if (i_inc && (r_cnt != {WIDTH{1'b1}})) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/eth_mac_stats_counters.sv
// Purpose : per-event saturating statistics counters for the 1G MAC, with a
//           valid/ready read port (optional clear-on-read) and a global clear.
// Ports   :
//   logic_clk, logic_rst       clock, asynchronous active-high reset
//   events_i[NUM_EVENTS]       one-cycle event strobes, bit i counts into counter i
//   clear_all_i                zero every counter (coincident events still count)
//   rd_v_i/rd_ready_o          read request handshake
//   rd_idx_i, rd_clr_i         counter to read, clear it after the read
//   resp_v_o/resp_ready_i      response handshake
//   resp_data_o, resp_err_o    sampled count, out-of-range index flag
// Option  : define ETH_STATS_IRQ_EN to add irq_mask_w_i, irq_mask_i and irq_o
//           (sticky per-event pending bits gated by a mask).
module eth_mac_stats_counters
  import eth_stats_pkg::*;
#(
  parameter  int unsigned NUM_EVENTS = ETH_STATS_NUM_EVENTS,
  parameter  int unsigned CNT_WIDTH  = 32,
  localparam int unsigned IDX_WIDTH  = idx_width(NUM_EVENTS)
) (
  input  logic                  logic_clk,
  input  logic                  logic_rst,
  input  logic [NUM_EVENTS-1:0] events_i,
  input  logic                  clear_all_i,
  input  logic                  rd_v_i,
  output logic                  rd_ready_o,
  input  logic [IDX_WIDTH-1:0]  rd_idx_i,
  input  logic                  rd_clr_i,
  output logic                  resp_v_o,
  input  logic                  resp_ready_i,
  output logic [CNT_WIDTH-1:0]  resp_data_o,
  output logic                  resp_err_o
`ifdef ETH_STATS_IRQ_EN
  ,
  input  logic                  irq_mask_w_i,
  input  logic [NUM_EVENTS-1:0] irq_mask_i,
  output logic                  irq_o
`endif
);

  resp_state_e           r_state;
  resp_state_e           w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_resp_data;
  logic                  r_resp_err;
  logic                  w_accept;
  logic                  w_idx_ok;
  logic [CNT_WIDTH-1:0]  w_rd_sel;
  logic [NUM_EVENTS-1:0] w_clr;
  logic [CNT_WIDTH-1:0]  w_cnt [NUM_EVENTS];

  assign resp_v_o   = (r_state == E_RESP);
  assign rd_ready_o = !resp_v_o || resp_ready_i;
  assign w_accept   = rd_v_i && rd_ready_o;
  assign w_idx_ok   = (32'(rd_idx_i) < NUM_EVENTS);

  // Read mux (zero for out-of-range) and per-counter clear strobes.
  always_comb begin
    w_rd_sel = '0;
    w_clr    = '0;
    for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
      if (32'(rd_idx_i) == i) begin
        w_rd_sel = w_cnt[i];
      end
      w_clr[i] = clear_all_i || (w_accept && rd_clr_i && (32'(rd_idx_i) == i));
    end
  end

  // Counter bank.
  for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_cnt
    eth_stats_sat_counter #(
      .WIDTH (CNT_WIDTH)
    ) u_cnt (
      .i_clk (logic_clk),
      .i_rst (logic_rst),
      .i_inc (events_i[g]),
      .i_clr (w_clr[g]),
      .o_cnt (w_cnt[g])
    );
  end

  // Response FSM state register.
  always_ff @(posedge logic_clk or posedge logic_rst) begin
    if (logic_rst) begin
      r_state <= E_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Response FSM next state; an accept while draining keeps RESP (back-to-back).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      E_IDLE:  if (w_accept) w_state_nxt = E_RESP;
      E_RESP:  if (resp_ready_i && !w_accept) w_state_nxt = E_IDLE;
      default: w_state_nxt = E_IDLE;
    endcase
  end

  // Response payload: captured only on accept, so it holds while stalled.
  always_ff @(posedge logic_clk or posedge logic_rst) begin
    if (logic_rst) begin
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
    end else if (w_accept) begin
      r_resp_data <= w_rd_sel;
      r_resp_err  <= !w_idx_ok;
    end
  end

  assign resp_data_o = r_resp_data;
  assign resp_err_o  = r_resp_err;

`ifdef ETH_STATS_IRQ_EN
  logic [NUM_EVENTS-1:0] r_pending;
  logic [NUM_EVENTS-1:0] r_mask;
  logic                  r_irq;
  logic [NUM_EVENTS-1:0] w_pending_nxt;
  logic [NUM_EVENTS-1:0] w_mask_nxt;

  // A coincident event re-sets a pending bit that is being cleared.
  assign w_pending_nxt = (r_pending & ~w_clr) | events_i;
  assign w_mask_nxt    = irq_mask_w_i ? irq_mask_i : r_mask;

  // irq is built from next-state values so it always equals |(pending & mask).
  always_ff @(posedge logic_clk or posedge logic_rst) begin
    if (logic_rst) begin
      r_pending <= '0;
      r_mask    <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      r_mask    <= w_mask_nxt;
      r_irq     <= |(w_pending_nxt & w_mask_nxt);
    end
  end

  assign irq_o = r_irq;
`else
  // No interrupt logic in this build.
`endif

endmodule

// File: tb/tb_eth_mac_stats_counters.sv
// Purpose : self-checking bench for eth_mac_stats_counters. Two instances
//           (32-bit and 4-bit counters) share one stimulus stream and are
//           checked every cycle against an array-based model; directed
//           sequences add literal expectations, then random traffic follows.
module tb_eth_mac_stats_counters;

  localparam int unsigned NE = 9;
  localparam int unsigned IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NE-1:0] ev;
  logic          clr_all, rd_v, rd_clr, rresp;
  logic [IW-1:0] idx;
  logic          rdy32, v32, err32, rdy4, v4, err4;
  logic [31:0]   data32;
  logic [3:0]    data4;
  logic          irq_w;
  logic [NE-1:0] irq_m;
  logic          irq32, irq4;

  always #5 clk = ~clk;

  eth_mac_stats_counters #(.NUM_EVENTS(NE), .CNT_WIDTH(32)) dut32 (
    .logic_clk(clk), .logic_rst(rst), .events_i(ev), .clear_all_i(clr_all),
    .rd_v_i(rd_v), .rd_ready_o(rdy32), .rd_idx_i(idx), .rd_clr_i(rd_clr),
    .resp_v_o(v32), .resp_ready_i(rresp), .resp_data_o(data32), .resp_err_o(err32)
`ifdef ETH_STATS_IRQ_EN
    , .irq_mask_w_i(irq_w), .irq_mask_i(irq_m), .irq_o(irq32)
`endif
  );

  eth_mac_stats_counters #(.NUM_EVENTS(NE), .CNT_WIDTH(4)) dut4 (
    .logic_clk(clk), .logic_rst(rst), .events_i(ev), .clear_all_i(clr_all),
    .rd_v_i(rd_v), .rd_ready_o(rdy4), .rd_idx_i(idx), .rd_clr_i(rd_clr),
    .resp_v_o(v4), .resp_ready_i(rresp), .resp_data_o(data4), .resp_err_o(err4)
`ifdef ETH_STATS_IRQ_EN
    , .irq_mask_w_i(irq_w), .irq_mask_i(irq_m), .irq_o(irq4)
`endif
  );

`ifndef ETH_STATS_IRQ_EN
  assign irq32 = 1'b0;
  assign irq4  = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state.
  longint unsigned m32 [NE];
  int unsigned     m4  [NE];
  bit              m_v, m_err, m_irq;
  longint unsigned m_d32;
  int unsigned     m_d4;
  bit [NE-1:0]     m_pend, m_mask;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      m32[i] = 0;
      m4[i]  = 0;
    end
    m_v = 0; m_err = 0; m_d32 = 0; m_d4 = 0;
    m_pend = '0; m_mask = '0; m_irq = 0;
  endtask

  // Drive one cycle of inputs, check outputs against the model, advance model.
  task automatic step(input logic [NE-1:0] e, input logic ca, input logic rv,
                      input logic [IW-1:0] ix, input logic rc, input logic rr);
    bit acc, ok, clr;
    ev = e; clr_all = ca; rd_v = rv; idx = ix; rd_clr = rc; rresp = rr;
    #1;
    chk("resp_v32", v32, m_v);
    chk("resp_v4", v4, m_v);
    chk("rd_ready32", rdy32, !m_v || rr);
    chk("rd_ready4", rdy4, !m_v || rr);
    if (m_v) begin
      chk("data32", data32, m_d32);
      chk("data4", data4, m_d4);
      chk("err32", err32, m_err);
      chk("err4", err4, m_err);
    end
`ifdef ETH_STATS_IRQ_EN
    chk("irq32", irq32, m_irq);
    chk("irq4", irq4, m_irq);
`endif
    acc = rv && (!m_v || rr);
    ok  = (int'(ix) < NE);
    if (acc) begin
      m_v = 1; m_err = !ok; m_d32 = 0; m_d4 = 0;
      if (ok) begin
        m_d32 = m32[ix];
        m_d4  = m4[ix];
      end
    end else if (rr) begin
      m_v = 0;
    end
    for (int i = 0; i < NE; i++) begin
      clr = ca || (acc && rc && ok && (int'(ix) == i));
      if (clr) begin
        m32[i] = longint'(e[i]);
        m4[i]  = int'(e[i]);
      end else if (e[i]) begin
        if (m32[i] < 64'hFFFF_FFFF) m32[i]++;
        if (m4[i] < 15) m4[i]++;
      end
      if (e[i]) m_pend[i] = 1;
      else if (clr) m_pend[i] = 0;
    end
    if (irq_w) m_mask = irq_m;
    m_irq = |(m_pend & m_mask);
    @(negedge clk);
  endtask

  initial begin
    rst = 1; ev = '0; clr_all = 0; rd_v = 0; idx = '0; rd_clr = 0; rresp = 0;
    irq_w = 0; irq_m = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_resp_v", v32, 0);
    chk("rst_data", data32, 0);
    chk("rst_err", err32, 0);
    chk("rst_ready", rdy32, 1);
    chk("rst_irq", irq32, 0);
    rst = 0;

    // Count and non-destructive re-read.
    repeat (5) step(9'h008, 0, 0, 0, 0, 1);
    step('0, 0, 1, 3, 0, 1);
    chk("t1_read", data32, 5);
    step('0, 0, 1, 3, 0, 1);
    chk("t1_reread", data32, 5);

    // Clear-on-read with coincident event.
    repeat (7) step(9'h020, 0, 0, 0, 0, 1);
    step(9'h020, 0, 1, 5, 1, 1);
    chk("t3_clr_read", data32, 7);
    step('0, 0, 1, 5, 0, 1);
    chk("t3_after_clr", data32, 1);
    chk("t3_after_clr4", data4, 1);

    // Stall then back-to-back reads; counters 0/1/2 = 2/1/3.
    step(9'h007, 0, 0, 0, 0, 1);
    step(9'h001, 0, 0, 0, 0, 1);
    step(9'h004, 0, 0, 0, 0, 1);
    step(9'h004, 0, 0, 0, 0, 1);
    step('0, 0, 1, 3, 0, 0);
    repeat (3) begin
      step('0, 0, 0, 0, 0, 0);
      chk("t4_stall_ready", rdy32, 0);
      chk("t4_stall_data", data32, 5);
    end
    step('0, 0, 1, 0, 0, 1);
    chk("t4_b2b0", data32, 2);
    step('0, 0, 1, 1, 0, 1);
    chk("t4_b2b1", data32, 1);
    step('0, 0, 1, 2, 0, 1);
    chk("t4_b2b2", data32, 3);
    chk("t4_b2b2_v", v32, 1);
    step('0, 0, 0, 0, 0, 1);

    // Saturation of the 4-bit instance.
    repeat (20) step(9'h001, 0, 0, 0, 0, 1);
    step('0, 0, 1, 0, 0, 1);
    chk("t2_wide", data32, 22);
    chk("t2_sat4", data4, 15);

    // Out-of-range index, then global clear with a coincident event.
    step('0, 0, 1, 12, 0, 1);
    chk("t5_err", err32, 1);
    chk("t5_err_data", data32, 0);
    step('0, 0, 1, 3, 0, 1);
    chk("t5_unchanged", data32, 5);
    step(9'h004, 1, 0, 0, 0, 1);
    step('0, 0, 1, 2, 0, 1);
    chk("t5_clr_keep", data32, 1);
    step('0, 0, 1, 3, 0, 1);
    chk("t5_clr_zero", data32, 0);
    step('0, 0, 0, 0, 0, 1);

`ifdef ETH_STATS_IRQ_EN
    irq_w = 1; irq_m = 9'h010;
    step('0, 0, 0, 0, 0, 1);
    irq_w = 0;
    step(9'h002, 0, 0, 0, 0, 1);
    chk("t6_masked", irq32, 0);
    step(9'h010, 0, 0, 0, 0, 1);
    chk("t6_irq_set", irq32, 1);
    step('0, 0, 1, 4, 1, 1);
    chk("t6_irq_clr", irq32, 0);
`endif

    // Asynchronous reset while a response is pending.
    step('0, 0, 1, 3, 0, 0);
    chk("t6_resp_pending", v32, 1);
    #2 rst = 1;
    #1 chk("t6_async_rst", v32, 0);
    rd_v = 0;
    model_reset();
    @(negedge clk);
    rst = 0;

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [NE-1:0] e;
      e = NE'($urandom & $urandom);
      irq_w = ($urandom_range(0, 15) == 0);
      irq_m = NE'($urandom);
      step(e, ($urandom_range(0, 31) == 0), ($urandom_range(0, 1) == 1),
           IW'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) < 7));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
